// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// It handles one input bit per clock. The block sits in front of the 7-segment
// encoder and LED multiplexer. It turns a binary count into NDIG packed BCD
// digits and a leading-zero blank mask, so the display shows a decimal value.
//
// Parameters
//   BIN_W      width of the binary input (27 bits covers 0..99,999,999)
//   NDIG       number of BCD digits produced (1..9)
//
// Ports
//   Clk        system clock; all state changes on the rising edge
//   Rst        synchronous, active-high reset
//   start      conversion request; sampled only while the block is idle
//   bin_in     binary value; captured on the edge that accepts start
//   busy       high while a conversion is in flight (CONV and FIN)
//   done       one-cycle pulse; bcd_out/lz_mask/ovf are valid from this cycle
//   ovf        the last result exceeded 10^NDIG-1
//   bcd_out    digit i in [4i+3:4i]; digit 0 is least significant
//   lz_mask    bit i set: digit i is a leading zero (the display blanks it)
//   state_dbg  current FSM state (0 IDLE, 1 CONV, 2 FIN), for observation
//
// Handshake: a request is accepted on a rising edge where start=1, the FSM is
// IDLE and done=0. The busy=0 / done=0 pair acts as "ready" and start acts as
// "valid". bin_in needs to be stable only on that edge. A start seen during
// busy or during the done cycle is dropped and not queued. A start held high
// begins a new conversion every time the block becomes ready again.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W = 27,
    parameter int NDIG  = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     lz_mask,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int DIG_W = 4 * NDIG;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    // In the reset mask only digit 0 is shown, so the display reads "0".
    localparam logic [NDIG-1:0] LZ_RST = {NDIG{1'b1}} << 1;

    // Largest value that fits in NDIG decimal digits, i.e. 10^NDIG - 1.
    function automatic logic [63:0] max_decimal(input int ndig);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_decimal(NDIG);

    // If every BIN_W-bit value fits in NDIG digits, the range compare below
    // folds to a constant 0 and no comparator is built.
    localparam bit OVF_POSSIBLE = (BIN_W >= 64) ||
                                  (((64'd1 << BIN_W) - 64'd1) > MAX_DEC);

    state_t              state;
    logic [BIN_W-1:0]    shift_q;
    logic [DIG_W-1:0]    dig_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_pend;

    logic                over_range;
    logic [DIG_W-1:0]    dig_adj;
    logic [DIG_W-1:0]    dig_shift;
    logic [NDIG-1:0]     lz_calc;
    logic                all_zero;

    assign state_dbg  = state;
    assign over_range = OVF_POSSIBLE && (64'(bin_in) > MAX_DEC);

    // Add-3 correction. Any digit of 5 or more gets +3 before the shift, so
    // that after doubling it carries cleanly into the next digit up.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the corrected digits left by one bit. The next binary MSB enters
    // at the bottom of digit 0.
    assign dig_shift = {dig_adj[DIG_W-2:0], shift_q[BIN_W-1]};

    // Digit i (i >= 1) is a leading zero when it and every digit above it
    // are zero. Digit 0 is always shown.
    always_comb begin
        lz_calc  = '0;
        all_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            all_zero   = all_zero && (dig_q[4*i +: 4] == 4'd0);
            lz_calc[i] = all_zero;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd_out  <= '0;
            lz_mask  <= LZ_RST;
            shift_q  <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Blocking start during the done cycle puts one idle cycle
                    // between results when start is held high.
                    if (start && !done) begin
                        shift_q <= bin_in;
                        dig_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        if (over_range) begin
                            ovf_pend <= 1'b1;
                            state    <= ST_FIN;
                        end else begin
                            ovf_pend <= 1'b0;
                            state    <= ST_CONV;
                        end
                    end
                end

                ST_CONV: begin
                    dig_q   <= dig_shift;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (ovf_pend) begin
                        ovf     <= 1'b1;
                        bcd_out <= {DIG_W{1'b1}};
                        lz_mask <= '0;
                    end else begin
                        ovf     <= 1'b0;
                        bcd_out <= dig_q;
                        lz_mask <= lz_calc;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Only values <= 10^NDIG-1 reach CONV. A partial value never exceeds the
    // final one, so the top digit never carries out of the digit register.
    top_digit_no_carry: assert property (
        @(posedge Clk) disable iff (Rst)
        (state == ST_CONV) |-> !dig_adj[DIG_W-1]
    );

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Bench for bin_to_bcd_seq with the default parameters (BIN_W=27, NDIG=8).
// Expected results come from a decimal reference model: digits by /10 and %10,
// leading zeros from magnitude against powers of ten. Each result is queued
// when the bench drives an accepted start and is popped on each done pulse.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 27;
    localparam int NDIG  = 8;
    localparam int EXP_W = 1 + NDIG + 4 * NDIG;   // {ovf, lz_mask, bcd_out}
    localparam logic [BIN_W-1:0] MAXV = 27'd99999999;

    // ---------------- clock / reset ----------------
    logic                Clk;
    logic                Rst;
    logic                start;
    logic [BIN_W-1:0]    bin_in;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [4*NDIG-1:0]   bcd_out;
    logic [NDIG-1:0]     lz_mask;
    logic [1:0]          state_dbg;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .bcd_out   (bcd_out),
        .lz_mask   (lz_mask),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain decimal arithmetic.
    function automatic logic [EXP_W-1:0] ref_model(input logic [BIN_W-1:0] v);
        logic [4*NDIG-1:0] bcd;
        logic [NDIG-1:0]   lz;
        int unsigned       x;
        int unsigned       p;
        if (v > MAXV) begin
            return {1'b1, {NDIG{1'b0}}, {(4*NDIG){1'b1}}};
        end
        x   = 32'(v);
        bcd = '0;
        for (int i = 0; i < NDIG; i++) begin
            bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        lz = '0;
        p  = 10;
        for (int i = 1; i < NDIG; i++) begin
            lz[i] = (32'(v) < p);
            p = p * 10;
        end
        return {1'b0, lz, bcd};
    endfunction

    function automatic logic [BIN_W-1:0] rnd_value();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 27'(99999999 + $urandom_range(0, 1));
        return 27'($urandom_range(0, 134217727));
    endfunction

    // Compare every result against the head of the expected queue.
    always @(negedge Clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_e = exp_q.pop_front();
                check("bcd_out", 64'(bcd_out), 64'(exp_e[4*NDIG-1:0]));
                check("lz_mask", 64'(lz_mask), 64'(exp_e[4*NDIG +: NDIG]));
                check("ovf",     64'(ovf),     64'(exp_e[EXP_W-1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Single conversion with latency and busy-width checks. With poke set, a
    // one-cycle start pulse carrying bin_in=5 is driven mid-conversion.
    task automatic convert(input logic [BIN_W-1:0] v, input bit poke);
        int k;
        int busy_cnt;
        int exp_lat;
        bit seen;
        exp_lat = (v > MAXV) ? 1 : 28;
        @(negedge Clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge Clk);
        exp_q.push_back(ref_model(v));
        #1;
        start    = 1'b0;
        seen     = 1'b0;
        busy_cnt = 0;
        k        = 0;
        while (!seen && k <= 60) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (poke && k == 5) begin
                    start  = 1'b1;
                    bin_in = 27'd5;
                end else begin
                    start  = 1'b0;
                    bin_in = v;
                end
                @(posedge Clk);
                #1;
                k++;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(k), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("busy_in_done", 64'(busy), 64'(0));
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge Clk);
            k++;
        end
        check("drain_in_time", 64'(k < 100), 64'(1));
        @(posedge Clk);
        #1;
    endtask

    // Start held high. The bench predicts the accepting edges from the
    // protocol: 30 edges apart for a normal result, 3 for an overflow.
    task automatic run_held(input int n_conv, input bit rand_mode);
        int accepted;
        int wait_edges;
        logic [BIN_W-1:0] step_v;
        logic [EXP_W-1:0] r;
        accepted   = 0;
        wait_edges = 0;
        step_v     = '0;
        @(negedge Clk);
        start  = 1'b1;
        bin_in = rand_mode ? rnd_value() : step_v;
        while (accepted < n_conv) begin
            @(posedge Clk);
            if (wait_edges == 0) begin
                r = ref_model(bin_in);
                exp_q.push_back(r);
                accepted++;
                wait_edges = r[EXP_W-1] ? 2 : 29;
                step_v     = step_v + 27'd1;
            end else begin
                wait_edges--;
            end
            @(negedge Clk);
            if (accepted == n_conv) start = 1'b0;
            bin_in = rand_mode ? rnd_value() : step_v;
        end
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        check("rst_busy",  64'(busy),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_ovf",   64'(ovf),       64'(0));
        check("rst_bcd",   64'(bcd_out),   64'(0));
        check("rst_lz",    64'(lz_mask),   64'(8'hFE));
        check("rst_state", 64'(state_dbg), 64'(0));

        convert(27'd0, 1'b0);
        check("zero_lz", 64'(lz_mask), 64'(8'hFE));
        convert(27'd12345678, 1'b0);
        check("full_bcd", 64'(bcd_out), 64'(32'h12345678));
        convert(27'd99999999, 1'b0);
        convert(27'd100000000, 1'b0);
        check("ovf_hold", 64'(ovf), 64'(1));
        convert(27'd134217727, 1'b0);
        convert(27'd1000, 1'b1);
        check("poke_ignored", 64'(bcd_out), 64'(32'h00001000));

        // Abort a conversion with reset at CONV cycle 10.
        @(negedge Clk);
        bin_in = 27'd12345678;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("abort_busy",  64'(busy),      64'(0));
        check("abort_done",  64'(done),      64'(0));
        check("abort_bcd",   64'(bcd_out),   64'(0));
        check("abort_lz",    64'(lz_mask),   64'(8'hFE));
        check("abort_ovf",   64'(ovf),       64'(0));
        check("abort_state", 64'(state_dbg), 64'(0));
        repeat (40) @(posedge Clk);
        convert(27'd42, 1'b0);
        check("after_abort", 64'(bcd_out), 64'(32'h00000042));

        run_held(21, 1'b0);
        run_held(1000, 1'b1);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
